pipe_exec_ctrl: RTL
===================

// Module: pipe_exec_ctrl
// PURPOSE
//  Run/step/halt controller for the N-stage MIPS pipeline. Sits beside the datapath top and
//  gates every pipeline register and PC write through o_stage_en. On a HALT decoded in ID it
//  stops fetch and drains in-flight instructions to WB before flagging done. Adds continuous
//  and single-step modes plus cycle and retired-instruction counters for the debug unit.
// PARAMETERS
//  N_STAGES  5   pipeline depth; o_stage_en[0]=PC/IF ... o_stage_en[N_STAGES-1]=WB (min 3)
//  CNTBITS   32  width of cycle and retired counters
// PORTS
//  i_clk            in   1         clock, all state updates on rising edge
//  i_rst            in   1         asynchronous, active-low reset
//  i_step_mode      in   1         1 = single-step, 0 = continuous; sampled in IDLE only
//  i_run            in   1         start pulse (continuous mode)
//  i_step           in   1         advance-one-cycle pulse (step mode)
//  i_clear          in   1         HALTED -> IDLE, zeroes counters
//  i_halt_id        in   1         HALT opcode present in ID stage (combinational from decoder)
//  i_wb_valid       in   1         WB stage holds a real instruction (not bubble)
//  o_stage_en       out  N_STAGES  per-stage register enable
//  o_if_bubble      out  1         force NOP into IF/ID register
//  o_busy           out  1         state is RUN, STEP_WAIT or DRAIN
//  o_done           out  1         state is HALTED
//  o_cycle_cnt      out  CNTBITS   enabled cycles since clear
//  o_retired_cnt    out  CNTBITS   instructions retired since clear
// BEHAVIOUR
//  - Reset (async, i_rst=0): state IDLE, o_stage_en=0, o_if_bubble=0, o_busy=0, o_done=0,
//    both counters 0, drain counter 0. Reset mid-RUN/DRAIN aborts immediately, no drain.
//  - States: IDLE, RUN, STEP_WAIT, DRAIN, HALTED. Outputs Moore except o_stage_en in STEP_WAIT.
//  - IDLE: stage_en=0. i_run & ~i_step_mode -> RUN. i_step_mode -> STEP_WAIT (i_run ignored).
//  - RUN: stage_en all 1. i_halt_id -> DRAIN same edge; HALT itself is latched into ID/EX.
//  - STEP_WAIT: stage_en = {N_STAGES{i_step}} (one cycle per pulse; level-held i_step = run).
//    i_halt_id & i_step -> DRAIN. i_halt_id without i_step: no transition.
//  - DRAIN: stage_en[0]=0 (PC frozen), others 1, o_if_bubble=1. Drain counter loads
//    N_STAGES-2 on entry, decrements each cycle; at 0 -> HALTED (HALT has reached WB).
//    Drain runs autonomously in both modes; i_step/i_run ignored.
//  - HALTED: stage_en=0, o_done=1. i_clear -> IDLE with counters zeroed. Other inputs ignored.
//  - i_halt_id in IDLE/DRAIN/HALTED ignored.
//  - o_cycle_cnt += 1 every cycle any stage_en bit is 1. Wraps modulo 2^CNTBITS.
//  - o_retired_cnt += 1 when stage_en[N_STAGES-1] & i_wb_valid. Wraps modulo 2^CNTBITS.
//  - HALT instruction counts as retired (decoder drives i_wb_valid for it).
//  - i_clear outside HALTED has no effect.
// STRUCTURE
//  - Shared header pipe_ctrl_defs.vh: state encodings (3-bit localparams), ST_IDLE..ST_HALTED.
//  - Sub-module en_counter #(W): sync enable, sync clear, async active-low reset, wrapping;
//    instantiated twice (cycle, retired). Drain counter and FSM inline.
// TESTING
//  - Reset: assert i_rst=0 mid-DRAIN -> all outputs 0, state IDLE within same cycle.
//  - Continuous: i_run, i_halt_id at cycle 10 -> DRAIN 3 cycles (N_STAGES=5), o_done at
//    cycle 14; o_cycle_cnt=13; stage_en[0]=0 and o_if_bubble=1 during drain.
//  - Step: 4 i_step pulses with gaps -> exactly 4 enabled cycles, o_cycle_cnt=4, stalls between.
//  - Step + halt: i_halt_id with no i_step holds STEP_WAIT; next i_step -> DRAIN, HALTED 3 later.
//  - Retire count: i_wb_valid=1 on 7 enabled cycles, 0 on 3 -> o_retired_cnt=7; i_clear -> 0.
//  - Wrap: CNTBITS=4, 17 enabled cycles -> o_cycle_cnt=1; simultaneous i_run&i_step_mode -> STEP_WAIT.

Source files
------------

// File: rtl/pipe_exec_ctrl_pkg.sv
// Shared types for the pipeline run/step/halt controller.
// The state encoding lives here so the controller and any debug logic agree on it.
package pipe_exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  function automatic logic is_busy(state_t s);
    return s inside {ST_RUN, ST_STEP_WAIT, ST_DRAIN};
  endfunction

endpackage

// File: rtl/pipe_exec_ctrl_en_counter.sv
// Wrapping up-counter with synchronous enable and synchronous clear.
// Clear wins over enable so a clear on an enabled cycle still lands at zero.
module pipe_exec_ctrl_en_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Run/step/halt controller: gates every pipeline register enable, drains the pipe after a
// HALT is decoded, and keeps cycle / retired-instruction counters for the debug unit.
module pipe_exec_ctrl
  import pipe_exec_ctrl_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int CNTBITS  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_step_mode,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_clear,
  input  logic                i_halt_id,
  input  logic                i_wb_valid,
  output logic [N_STAGES-1:0] o_stage_en,
  output logic                o_if_bubble,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNTBITS-1:0]  o_cycle_cnt,
  output logic [CNTBITS-1:0]  o_retired_cnt
);

  localparam int DW = $clog2(N_STAGES);
  // HALT is already in ID/EX when the drain begins, so it needs N_STAGES-2 more cycles to reach WB.
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(N_STAGES - 2);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  state_t         state, state_nx;
  logic [DW-1:0]  drain_cnt, drain_nx;
  logic           cnt_clr;

  // NOTE: the async reset also clears the drain counter, so a reset mid-drain leaves no residue.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_nx;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    drain_nx = drain_cnt;
    unique case (state)
      ST_IDLE: begin
        if (i_step_mode)  state_nx = ST_STEP_WAIT;
        else if (i_run)   state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (i_halt_id) begin
          state_nx = ST_DRAIN;
          drain_nx = DRAIN_LOAD;
        end
      end
      ST_STEP_WAIT: begin
        if (i_halt_id && i_step) begin
          state_nx = ST_DRAIN;
          drain_nx = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // The decrement that reaches zero is the edge on which HALT retires from WB.
        drain_nx = drain_cnt - DRAIN_ONE;
        if (drain_cnt == DRAIN_ONE) state_nx = ST_HALTED;
      end
      ST_HALTED: begin
        if (i_clear) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    o_stage_en  = '0;
    o_if_bubble = 1'b0;
    o_busy      = is_busy(state);
    o_done      = (state == ST_HALTED);
    unique case (state)
      ST_RUN:       o_stage_en = '1;
      ST_STEP_WAIT: o_stage_en = {N_STAGES{i_step}};
      ST_DRAIN: begin
        o_stage_en  = {{(N_STAGES-1){1'b1}}, 1'b0};
        o_if_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign cnt_clr = (state == ST_HALTED) && i_clear;

  pipe_exec_ctrl_en_counter #(.W(CNTBITS)) u_cycle_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (|o_stage_en),
    .i_clr (cnt_clr),
    .o_cnt (o_cycle_cnt)
  );

  pipe_exec_ctrl_en_counter #(.W(CNTBITS)) u_retired_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (o_stage_en[N_STAGES-1] && i_wb_valid),
    .i_clr (cnt_clr),
    .o_cnt (o_retired_cnt)
  );

endmodule
